// File: rtl/squash_pkg.sv
// Shared types and constants for the squash rally controller.
package squash_pkg;

    localparam int unsigned COURT_LEN = 16;
    localparam int unsigned POS_W     = $clog2(COURT_LEN);
    localparam logic [1:0]  WIN_SCORE = 2'd3;

    localparam int unsigned DEF_TICK_INIT = 25_000_000;
    localparam int unsigned DEF_TICK_STEP = 1_000_000;
    localparam int unsigned DEF_TICK_MIN  = 5_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_TO_WALL,
        ST_FROM_WALL,
        ST_POINT,
        ST_GAMEOVER
    } state_e;

    function automatic logic [COURT_LEN-1:0] court_onehot(input logic [POS_W-1:0] pos);
        court_onehot      = '0;
        court_onehot[pos] = 1'b1;
    endfunction

    function automatic logic [1:0] score_inc(input logic [1:0] score);
        score_inc = (score == WIN_SCORE) ? score : score + 2'd1;
    endfunction

endpackage

// File: rtl/rally_timer.sv
// Step tick generator: pulses when the counter reaches period-1, then restarts.
module rally_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] period_i,
    input  logic        clear_i,
    output logic        tick_o
);

    logic [31:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == period_i - 32'd1);

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/squash_rally_ctrl.sv
// Single-player-pair squash rally: serve, wall bounce, hit window, faults and scoring.
// state        | meaning
// ST_IDLE      | waiting for any press to start a game
// ST_SERVE     | ball at player end, waiting for the turn player to serve
// ST_TO_WALL   | ball travelling toward the wall
// ST_FROM_WALL | ball returning; pos 0 is the hit window
// ST_POINT     | point just scored, court lit for one period
// ST_GAMEOVER  | a player reached the winning score
module squash_rally_ctrl
    import squash_pkg::*;
#(
    parameter int unsigned TICK_INIT = DEF_TICK_INIT,
    parameter int unsigned TICK_STEP = DEF_TICK_STEP,
    parameter int unsigned TICK_MIN  = DEF_TICK_MIN
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 leftplayer_i,
    input  logic                 rightplayer_i,
    output logic [COURT_LEN-1:0] light_o,
    output logic [1:0]           leftpscore_o,
    output logic [1:0]           rightpscore_o,
    output logic                 gamestate_o,
    output logic                 turn_o
);

    state_e               state_q, state_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 turn_q, turn_d;
    logic [31:0]          period_q, period_d;
    logic [1:0]           lscore_q, lscore_d;
    logic [1:0]           rscore_q, rscore_d;
    logic [COURT_LEN-1:0] light_q, light_d;
    logic                 left_hist_q, right_hist_q, armed_q;
    logic                 left_press_q, right_press_q;
    logic                 tick;
    logic                 turn_press, opp_press, any_press;
    logic                 point_req, point_right;

    // armed_q masks the first sample after reset so a held button cannot fire
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            left_hist_q   <= 1'b0;
            right_hist_q  <= 1'b0;
            armed_q       <= 1'b0;
            left_press_q  <= 1'b0;
            right_press_q <= 1'b0;
        end else begin
            left_hist_q   <= leftplayer_i;
            right_hist_q  <= rightplayer_i;
            armed_q       <= 1'b1;
            left_press_q  <= armed_q & leftplayer_i & ~left_hist_q;
            right_press_q <= armed_q & rightplayer_i & ~right_hist_q;
        end
    end

    rally_timer u_timer (
        .clk_i    (clock_i),
        .rst_i    (reset_i),
        .period_i (period_q),
        .clear_i  (state_d != state_q),
        .tick_o   (tick)
    );

    assign turn_press = turn_q ? right_press_q : left_press_q;
    assign opp_press  = turn_q ? left_press_q  : right_press_q;
    assign any_press  = left_press_q | right_press_q;

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        turn_d      = turn_q;
        period_d    = period_q;
        lscore_d    = lscore_q;
        rscore_d    = rscore_q;
        point_req   = 1'b0;
        point_right = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_press) begin
                    state_d  = ST_SERVE;
                    pos_d    = '0;
                    turn_d   = 1'b0;
                    period_d = TICK_INIT;
                end
            end
            ST_SERVE: begin
                if (turn_press) begin
                    state_d = ST_TO_WALL;
                    pos_d   = POS_W'(1);
                    turn_d  = ~turn_q;
                end
            end
            ST_TO_WALL: begin
                // A turn-player fault outranks a simultaneous opponent press
                if (turn_press) begin
                    point_req   = 1'b1;
                    point_right = ~turn_q;
                end else if (opp_press) begin
                    point_req   = 1'b1;
                    point_right = turn_q;
                end else if (tick) begin
                    if (pos_q == POS_W'(COURT_LEN - 1)) begin
                        state_d = ST_FROM_WALL;
                        pos_d   = POS_W'(COURT_LEN - 2);
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end
            end
            ST_FROM_WALL: begin
                if (turn_press && pos_q == '0) begin
                    state_d  = ST_TO_WALL;
                    pos_d    = POS_W'(1);
                    turn_d   = ~turn_q;
                    period_d = (period_q >= TICK_MIN + TICK_STEP) ? period_q - TICK_STEP : TICK_MIN;
                end else if (turn_press) begin
                    point_req   = 1'b1;
                    point_right = ~turn_q;
                end else if (opp_press) begin
                    point_req   = 1'b1;
                    point_right = turn_q;
                end else if (tick) begin
                    if (pos_q == '0) begin
                        point_req   = 1'b1;
                        point_right = ~turn_q;
                    end else begin
                        pos_d = pos_q - POS_W'(1);
                    end
                end
            end
            ST_POINT: begin
                if (tick) begin
                    if (lscore_q == WIN_SCORE || rscore_q == WIN_SCORE) begin
                        state_d = ST_GAMEOVER;
                    end else begin
                        state_d  = ST_SERVE;
                        pos_d    = '0;
                        period_d = TICK_INIT;
                    end
                end
            end
            ST_GAMEOVER: begin
                if (any_press) begin
                    state_d  = ST_IDLE;
                    lscore_d = '0;
                    rscore_d = '0;
                    pos_d    = '0;
                    turn_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The point loser serves next, so turn is handed over on entry to POINT
        if (point_req) begin
            state_d = ST_POINT;
            turn_d  = ~point_right;
            if (point_right) begin
                rscore_d = score_inc(rscore_q);
            end else begin
                lscore_d = score_inc(lscore_q);
            end
        end

        case (state_d)
            ST_SERVE, ST_TO_WALL, ST_FROM_WALL: light_d = court_onehot(pos_d);
            ST_POINT, ST_GAMEOVER:              light_d = '1;
            default:                            light_d = '0;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            pos_q    <= '0;
            turn_q   <= 1'b0;
            period_q <= TICK_INIT;
            lscore_q <= '0;
            rscore_q <= '0;
            light_q  <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            turn_q   <= turn_d;
            period_q <= period_d;
            lscore_q <= lscore_d;
            rscore_q <= rscore_d;
            light_q  <= light_d;
        end
    end

    assign light_o       = light_q;
    assign leftpscore_o  = lscore_q;
    assign rightpscore_o = rscore_q;
    assign turn_o        = turn_q;
    assign gamestate_o   = (state_q == ST_SERVE) || (state_q == ST_TO_WALL) ||
                           (state_q == ST_FROM_WALL) || (state_q == ST_POINT);

endmodule
